// File: rtl/zoned_security_ctrl.sv
// Multi-zone intrusion controller: exit/entry delays, siren timeout with alarm memory,
// wrong-code lockout and latched tripped-zone reporting.
module zoned_security_ctrl #(
  parameter int unsigned         N_ZONES      = 8,
  parameter int unsigned         CODE_W       = 4,
  parameter logic [CODE_W-1:0]   ARM_CODE     = 4'b0011,
  parameter logic [CODE_W-1:0]   DISARM_CODE  = 4'b1100,
  parameter int unsigned         EXIT_DLY     = 30,
  parameter int unsigned         ENTRY_DLY    = 10,
  parameter int unsigned         SIREN_TIME   = 100,
  parameter int unsigned         MAX_BAD      = 3,
  parameter int unsigned         LOCKOUT_TIME = 50,
  parameter int unsigned         CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_ZONES-1:0] zone_in,
  input  logic [N_ZONES-1:0] zone_instant,
  input  logic [N_ZONES-1:0] zone_bypass,
  input  logic [CODE_W-1:0]  keypad,
  input  logic               key_valid,
  output logic               alarm_siren,
  output logic               armed_led,
  output logic [2:0]         state,
  output logic [N_ZONES-1:0] tripped_zones,
  output logic               arm_fail,
  output logic               locked_out
);

  localparam int unsigned BAD_W = $clog2(MAX_BAD + 1);

  typedef enum logic [2:0] {
    StDisarmed   = 3'd0,
    StExitDelay  = 3'd1,
    StArmed      = 3'd2,
    StEntryDelay = 3'd3,
    StAlarm      = 3'd4,
    StAlarmMem   = 3'd5
  } state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_lock_timer;
  logic [BAD_W-1:0]   r_bad_cnt;
  logic               r_locked;
  logic [N_ZONES-1:0] r_tripped;
  logic               r_siren;
  logic               r_led;
  logic               r_arm_fail;

  logic [N_ZONES-1:0] w_act, w_inst, w_dly;
  logic               w_key, w_disarm, w_bad, w_lock_start, w_arm_fail;

  assign w_act        = zone_in & ~zone_bypass;
  assign w_inst       = w_act & zone_instant;
  assign w_dly        = w_act & ~zone_instant;
  assign w_key        = key_valid & ~r_locked;
  assign w_disarm     = w_key && (keypad == DISARM_CODE) && (r_state != StDisarmed);
  assign w_bad        = w_key && (keypad != DISARM_CODE) && (r_state != StDisarmed);
  assign w_lock_start = w_bad && (r_bad_cnt == BAD_W'(MAX_BAD - 1));

  // Priority within each state: disarm > instant trip > delayed trip > timer expiry.
  always_comb begin
    w_state_d  = r_state;
    w_arm_fail = 1'b0;
    case (r_state)
      StDisarmed: begin
        if (w_key && (keypad == ARM_CODE)) begin
          if (w_act == '0) w_state_d = StExitDelay;
          else             w_arm_fail = 1'b1;
        end
      end
      StExitDelay: begin
        if (w_disarm)                                w_state_d = StDisarmed;
        else if (w_inst != '0)                       w_state_d = StAlarm;
        else if (r_timer == CNT_W'(EXIT_DLY - 1))    w_state_d = StArmed;
      end
      StArmed: begin
        if (w_disarm)          w_state_d = StDisarmed;
        else if (w_inst != '0) w_state_d = StAlarm;
        else if (w_dly != '0)  w_state_d = StEntryDelay;
      end
      StEntryDelay: begin
        if (w_disarm)                                w_state_d = StDisarmed;
        else if (w_inst != '0)                       w_state_d = StAlarm;
        else if (r_timer == CNT_W'(ENTRY_DLY - 1))   w_state_d = StAlarm;
        else if (w_lock_start)                       w_state_d = StAlarm;
      end
      StAlarm: begin
        if (w_disarm)                                w_state_d = StDisarmed;
        else if (r_timer == CNT_W'(SIREN_TIME - 1))  w_state_d = StAlarmMem;
      end
      StAlarmMem: begin
        if (w_disarm) w_state_d = StDisarmed;
      end
      default: w_state_d = StDisarmed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StDisarmed;
      r_timer    <= '0;
      r_siren    <= 1'b0;
      r_led      <= 1'b0;
      r_arm_fail <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_siren    <= (w_state_d == StAlarm);
      r_led      <= (w_state_d != StDisarmed);
      r_arm_fail <= w_arm_fail;
      if (w_state_d != r_state) begin
        r_timer <= '0;
      end else if ((r_state == StExitDelay) || (r_state == StEntryDelay) ||
                   (r_state == StAlarm)) begin
        r_timer <= r_timer + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_cnt    <= '0;
      r_locked     <= 1'b0;
      r_lock_timer <= '0;
    end else if (r_locked) begin
      if (r_lock_timer == CNT_W'(LOCKOUT_TIME - 1)) begin
        r_locked     <= 1'b0;
        r_bad_cnt    <= '0;
        r_lock_timer <= '0;
      end else begin
        r_lock_timer <= r_lock_timer + CNT_W'(1);
      end
    end else if (w_disarm) begin
      r_bad_cnt <= '0;
    end else if (w_bad) begin
      r_bad_cnt <= r_bad_cnt + BAD_W'(1);
      if (w_lock_start) begin
        r_locked     <= 1'b1;
        r_lock_timer <= '0;
      end
    end
  end

  // During exit delay only instant zones are recorded; delayed zones are expected to be open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tripped <= '0;
    end else if ((r_state == StDisarmed) && (w_state_d == StExitDelay)) begin
      r_tripped <= '0;
    end else begin
      case (r_state)
        StExitDelay:                               r_tripped <= r_tripped | w_inst;
        StArmed, StEntryDelay, StAlarm, StAlarmMem: r_tripped <= r_tripped | w_act;
        default:                                   r_tripped <= r_tripped;
      endcase
    end
  end

  assign alarm_siren   = r_siren;
  assign armed_led     = r_led;
  assign state         = r_state;
  assign tripped_zones = r_tripped;
  assign arm_fail      = r_arm_fail;
  assign locked_out    = r_locked;

endmodule

// File: tb/tb_zoned_security_ctrl.sv
// Directed self-checking bench for zoned_security_ctrl with default parameters.
module tb_zoned_security_ctrl;

  localparam logic [3:0] ArmCode    = 4'b0011;
  localparam logic [3:0] DisarmCode = 4'b1100;
  localparam logic [3:0] WrongCode  = 4'b0101;

  logic       clk;
  logic       rst_n;
  logic [7:0] zone_in;
  logic [7:0] zone_instant;
  logic [7:0] zone_bypass;
  logic [3:0] keypad;
  logic       key_valid;
  logic       alarm_siren;
  logic       armed_led;
  logic [2:0] state;
  logic [7:0] tripped_zones;
  logic       arm_fail;
  logic       locked_out;

  int n_checks = 0;
  int n_fail   = 0;

  zoned_security_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .zone_in      (zone_in),
    .zone_instant (zone_instant),
    .zone_bypass  (zone_bypass),
    .keypad       (keypad),
    .key_valid    (key_valid),
    .alarm_siren  (alarm_siren),
    .armed_led    (armed_led),
    .state        (state),
    .tripped_zones(tripped_zones),
    .arm_fail     (arm_fail),
    .locked_out   (locked_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] code);
    keypad    = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    keypad    = '0;
  endtask

  // Arm with all zones closed and wait out the full exit delay.
  task automatic arm_and_wait();
    key(ArmCode);
    repeat (30) tick();
    check("armed_after_exit", state, 32'd2);
  endtask

  int  n;
  logic siren_seen;

  initial begin
    rst_n = 1'b0; zone_in = '0; zone_instant = '0; zone_bypass = '0;
    keypad = '0; key_valid = 1'b0;
    repeat (3) tick();
    check("rst_state", state, 32'd0);
    check("rst_siren", alarm_siren, 32'd0);
    check("rst_led", armed_led, 32'd0);
    check("rst_tripped", tripped_zones, 32'd0);
    check("rst_flags", {arm_fail, locked_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Exit delay length
    key(ArmCode);
    check("exit_enter", state, 32'd1);
    check("exit_led", armed_led, 32'd1);
    n = 1;
    while (state == 3'd1 && n < 200) begin
      tick();
      if (state == 3'd1) n++;
    end
    check("exit_len", n, 32'd30);
    check("exit_to_armed", state, 32'd2);
    check("armed_led", armed_led, 32'd1);
    check("armed_siren", alarm_siren, 32'd0);

    // Delayed zone 2 pulse then disarm inside entry delay
    zone_in = 8'h04;
    tick();
    zone_in = 8'h00;
    check("entry_enter", state, 32'd3);
    siren_seen = alarm_siren;
    repeat (4) begin tick(); siren_seen |= alarm_siren; end
    key(DisarmCode);
    siren_seen |= alarm_siren;
    check("entry_disarm", state, 32'd0);
    check("entry_no_siren", siren_seen, 32'd0);
    check("tripped_z2", tripped_zones, 32'h04);
    check("disarm_led", armed_led, 32'd0);

    // Entry delay expiry, siren timeout, alarm memory
    arm_and_wait();
    check("arm_clears_tripped", tripped_zones, 32'h00);
    zone_in = 8'h01;
    tick();
    check("entry2_enter", state, 32'd3);
    n = 1;
    while (state == 3'd3 && n < 200) begin
      tick();
      if (state == 3'd3) n++;
    end
    zone_in = 8'h00;
    check("entry_len", n, 32'd10);
    check("alarm_state", state, 32'd4);
    check("alarm_siren_on", alarm_siren, 32'd1);
    n = 1;
    while (state == 3'd4 && n < 300) begin
      tick();
      if (state == 3'd4 && alarm_siren) n++;
    end
    check("siren_len", n, 32'd100);
    check("mem_state", state, 32'd5);
    check("mem_siren_off", alarm_siren, 32'd0);
    check("mem_led", armed_led, 32'd1);
    check("mem_tripped", tripped_zones, 32'h01);
    key(DisarmCode);
    check("mem_disarm", state, 32'd0);

    // Instant zone 5, then instant + disarm in the same cycle
    zone_instant = 8'h20;
    arm_and_wait();
    zone_in = 8'h20;
    tick();
    zone_in = 8'h00;
    check("inst_alarm", state, 32'd4);
    check("inst_siren", alarm_siren, 32'd1);
    check("inst_tripped", tripped_zones[5], 32'd1);
    key(DisarmCode);
    check("inst_disarm", state, 32'd0);
    arm_and_wait();
    zone_in = 8'h20;
    key(DisarmCode);
    zone_in = 8'h00;
    check("disarm_beats_inst", state, 32'd0);
    check("disarm_beats_siren", alarm_siren, 32'd0);

    // Delayed zone ignored in exit delay, then wrong-code lockout in entry delay
    key(ArmCode);
    zone_in = 8'h01;
    tick();
    zone_in = 8'h00;
    check("exit_ignores_dly", state, 32'd1);
    check("exit_no_dly_record", tripped_zones, 32'h00);
    repeat (29) tick();
    check("armed_again", state, 32'd2);
    zone_in = 8'h01;
    tick();
    zone_in = 8'h00;
    check("entry3_enter", state, 32'd3);
    key(WrongCode);
    key(WrongCode);
    check("two_bad_no_lock", {state, locked_out}, {3'd3, 1'b0});
    key(WrongCode);
    check("lock_alarm", state, 32'd4);
    check("lock_on", locked_out, 32'd1);
    n = 1;
    key(DisarmCode);
    if (locked_out) n++;
    check("lock_ignores_disarm", state, 32'd4);
    while (locked_out && n < 200) begin
      tick();
      if (locked_out) n++;
    end
    check("lock_len", n, 32'd50);
    key(DisarmCode);
    check("post_lock_disarm", {state, locked_out}, {3'd0, 1'b0});

    // Arm refusal, bypass, async reset in alarm
    zone_in = 8'h02;
    key(ArmCode);
    check("arm_fail_pulse", arm_fail, 32'd1);
    check("arm_fail_state", state, 32'd0);
    tick();
    check("arm_fail_clear", arm_fail, 32'd0);
    zone_bypass = 8'h02;
    key(ArmCode);
    check("bypass_arm", state, 32'd1);
    zone_in = 8'h22;
    tick();
    check("bypass_inst_alarm", state, 32'd4);
    check("bypass_tripped", tripped_zones, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {alarm_siren, armed_led, state, tripped_zones, arm_fail, locked_out},
          32'd0);
    zone_in = '0; zone_bypass = '0; zone_instant = '0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zoned_security_ctrl.md
Name: zoned_security_ctrl

Overview:
Multi-zone intrusion controller, parametrised successor to the single-loop security FSM. Adds:
- N zones, each with an instant/delayed mode and a bypass bit.
- Exit delay on arming and entry delay on delayed-zone trips.
- Siren timeout followed by an alarm-memory state.
- Wrong-code counting with keypad lockout, and latched tripped-zone reporting.

Sits between debounced sensor inputs and keypad decoder on one side, and the siren driver and status panel on the other.

Parameters:
N_ZONES, 8, number of sensor zones
CODE_W, 4, keypad code width
ARM_CODE, 4'b0011, arming code
DISARM_CODE, 4'b1100, disarm code
EXIT_DLY, 30, cycles spent in EXIT_DELAY
ENTRY_DLY, 10, cycles spent in ENTRY_DELAY
SIREN_TIME, 100, cycles siren stays on in ALARM
MAX_BAD, 3, consecutive wrong codes that trigger lockout
LOCKOUT_TIME, 50, cycles keypad is ignored after lockout
CNT_W, 32, width of state timer and lockout timer

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
zone_in  in  N_ZONES  1 = zone open/tripped (pre-debounced)
zone_instant  in  N_ZONES  1 = zone trips alarm with no entry delay
zone_bypass  in  N_ZONES  1 = zone ignored
keypad  in  CODE_W  entered code, valid only with key_valid
key_valid  in  1  one-cycle strobe per code entry
alarm_siren  out  1  siren drive
armed_led  out  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM, ALARM_MEM
state  out  3  0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 ENTRY_DELAY, 4 ALARM, 5 ALARM_MEM
tripped_zones  out  N_ZONES  latched record of zones that caused/joined an alarm event
arm_fail  out  1  one-cycle pulse: arm refused
locked_out  out  1  keypad lockout active

Behaviour:
- Registered outputs and state. Reset (rst_n=0, async) forces state=DISARMED, all outputs 0, timers 0, bad_cnt 0, tripped_zones 0. Reset mid-operation aborts any state or timer immediately.
- act = zone_in & ~zone_bypass. inst = act & zone_instant. dly = act & ~zone_instant.
- A key event is key_valid=1 && !locked_out. Events while locked_out are dropped and not counted.
- State timer:
  - Cleared on every state entry; increments each cycle in a timed state.
  - A timed state with length L exits when the timer reaches L-1, so it is occupied exactly L cycles.
- DISARMED:
  - Key event with ARM_CODE and act==0 -> EXIT_DELAY; tripped_zones cleared on this transition.
  - Key event with ARM_CODE and act!=0 -> stay; arm_fail pulses 1 cycle.
  - Other codes are ignored and not counted as wrong codes.
- EXIT_DELAY:
  - Disarm event -> DISARMED.
  - Else inst!=0 -> ALARM.
  - Else timer == EXIT_DLY-1 -> ARMED.
  - Delayed zones are ignored during this state.
- ARMED:
  - Disarm event -> DISARMED.
  - Else inst!=0 -> ALARM.
  - Else dly!=0 -> ENTRY_DELAY.
- ENTRY_DELAY:
  - Disarm event -> DISARMED. Disarm wins on the final cycle.
  - Else inst!=0 -> ALARM.
  - Else timer == ENTRY_DLY-1 -> ALARM.
  - Else lockout starting this cycle -> ALARM.
- ALARM:
  - alarm_siren=1.
  - Disarm event -> DISARMED.
  - Else timer == SIREN_TIME-1 -> ALARM_MEM.
- ALARM_MEM: siren off; armed_led=1; disarm event -> DISARMED. New trips are recorded in tripped_zones but do not restart the siren.
- Wrong codes:
  - In every state except DISARMED, a key event != DISARM_CODE increments bad_cnt.
  - When bad_cnt reaches MAX_BAD: locked_out=1 for LOCKOUT_TIME cycles, then bad_cnt=0 and locked_out=0.
  - A correct disarm clears bad_cnt.
  - Lockout does not change state, except in ENTRY_DELAY as above.
- tripped_zones:
  - OR-accumulates act in ARMED, ENTRY_DELAY, ALARM and ALARM_MEM. In EXIT_DELAY it accumulates inst only.
  - Holds its value through disarm; cleared only on arming or reset.
- Simultaneous events in one cycle: disarm > instant trip > delayed trip > timer expiry.
- Bypass changes take effect the same cycle they are applied.

Test Plan:
- ARM_CODE strobe, all zones closed, EXIT_DLY=30 -> state=1 for exactly 30 cycles, then state=2, armed_led=1, siren 0.
- ARMED; open delayed zone 2 for 1 cycle; DISARM_CODE 5 cycles later -> state 3 then 0, siren never 1, tripped_zones=8'h04.
- ARMED; open delayed zone 0; no key -> ALARM after exactly 10 cycles in ENTRY_DELAY; siren 1 for 100 cycles; then state=5, siren 0; DISARM -> state 0.
- ARMED; zone 5 instant opens -> next cycle state=4, siren=1, tripped_zones bit5=1. Same cycle with DISARM strobe -> state 0 instead.
- ENTRY_DELAY; three wrong codes -> locked_out=1, state=4 immediately; DISARM during 50-cycle lockout ignored; after lockout DISARM -> state 0, locked_out 0.
- DISARMED, zone 1 open (unbypassed), ARM_CODE -> arm_fail 1-cycle pulse, stays 0. Set bypass bit1 and ARM -> EXIT_DELAY. Drop rst_n during ALARM -> all outputs 0 asynchronously.
